wb_demux_router: RTL

- Registered, flow-controlled successor to the 1x16 writeback demux in the CPU writeback stage.
- Routes one input beat (select code + data) to one of NCH output channels. Each channel owns a single-entry holding register with a valid/ready handshake.
- Writeback-enable is per select code, set by a mask parameter instead of being hard-coded.
- Select codes without writeback, and out-of-range codes, are dropped and counted.

---
 rtl/wb_demux_router.sv | 129 ++++++++++++
 1 files changed

// File: rtl/wb_demux_router.sv
// wb_demux_router: routes one input beat (select code + data) to one of NCH
// output channels, each with a single-entry holding register and a
// valid/ready handshake. Codes without writeback, and codes >= NCH, are
// dropped and counted in a saturating counter.
// Optional build macro WB_ZERO_FILL_EN: in-range codes whose WB_MASK bit is 0
// are routed to their channel with zeroed data instead of being dropped.
module wb_demux_router #(
    parameter int          DATA_W  = 16,
    parameter int          NCH     = 16,
    parameter int          SEL_W   = $clog2(NCH),
    parameter logic [63:0] WB_MASK = 64'h0000_0000_0000_08FF,
    parameter int          CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic [DATA_W-1:0]     in_data,
    output logic [NCH-1:0]        out_valid,
    input  logic [NCH-1:0]        out_ready,
    output logic [NCH*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]      drop_cnt,
    output logic                  busy
);

    // Every value in_sel can take, including codes >= NCH.
    localparam int NCODE = 1 << SEL_W;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_t;

    chan_state_t         state  [NCH];
    logic [DATA_W-1:0]   data_q [NCH];

    logic [NCODE-1:0]    code_route;  // code goes to a channel
    logic [NCODE-1:0]    code_zero;   // code goes to a channel with zeroed data
    logic [NCODE-1:0]    free_pad;    // channel can take a beat this cycle
    logic [NCH-1:0]      fill;
    logic                route;
    logic                accept;
    logic [DATA_W-1:0]   fill_data;

    // Per-code routing table; constant after elaboration, so indexing it
    // with any in_sel value is safe even when in_sel >= NCH.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        code_route = '0;
        code_zero  = '0;
        for (int c = 0; c < NCODE; c++) begin
`ifdef WB_ZERO_FILL_EN
            code_route[c] = (c < NCH);
            code_zero[c]  = (c < NCH) && !WB_MASK[c];
`else
            code_route[c] = (c < NCH) && WB_MASK[c];
            code_zero[c]  = 1'b0;
`endif
        end
    end

    // Channel availability padded to NCODE so out-of-range codes read 0.
    always_comb begin
        free_pad          = '0;
        free_pad[NCH-1:0] = ~out_valid | out_ready;
    end

    // Handshake: depends only on in_sel and channel state, never on in_valid.
    always_comb begin
        route     = code_route[in_sel];
        in_ready  = route ? free_pad[in_sel] : 1'b1;
        accept    = in_valid && in_ready;
        fill_data = code_zero[in_sel] ? '0 : in_data;
        fill      = '0;
        for (int i = 0; i < NCH; i++) begin
            fill[i] = accept && route && (in_sel == SEL_W'(i));
        end
    end

    // Per-channel EMPTY/FULL state machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                // NOTE: sequential state uses <= so all channels update from the same pre-edge values.
                state[i] <= EMPTY;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                case (state[i])
                    EMPTY:   if (fill[i]) state[i] <= FULL;
                    FULL:    if (out_ready[i] && !fill[i]) state[i] <= EMPTY;
                    default: state[i] <= EMPTY;
                endcase
            end
        end
    end

    // Holding registers: load on fill, keep the last value after a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                // NOTE: the data storage is reset because out_data must read 0 out of reset.
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (fill[i]) data_q[i] <= fill_data;
            end
        end
    end

    // Saturating count of dropped beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (accept && !route && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    // Output flattening; busy comes straight from the state flops.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < NCH; i++) begin
            out_valid[i]                  = (state[i] == FULL);
            out_data[i*DATA_W +: DATA_W] = data_q[i];
        end
        busy = |out_valid;
    end

endmodule
